// File: rtl/qar_dmem_responder.sv
// -----------------------------------------------------------------------------
// qar_dmem_responder
//   Word-addressed 32-bit data memory slave with a valid/ready request
//   handshake, a configurable response latency, range/alignment fault
//   detection and good-read / good-write / fault counters.
//
// Parameters
//   DEPTH        number of 32-bit words in the storage array
//   ADDR_WIDTH   word-index width (log2 DEPTH)
//   WAIT_STATES  extra cycles (0..15) between acceptance and mem_ready
//   BASE_ADDR    byte address of word 0
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   mem_valid  in   request strobe, held by the initiator until mem_ready
//   mem_we     in   1 = write, 0 = read
//   mem_addr   in   byte address
//   mem_wdata  in   write data
//   mem_ready  out  one-cycle completion pulse
//   mem_rdata  out  read data (valid with mem_ready on reads, held otherwise)
//   mem_err    out  fault flag, only ever high together with mem_ready
//   rd_count   out  completed good reads (wrapping)
//   wr_count   out  completed good writes (wrapping)
//   err_count  out  faulting accesses (saturating)
// -----------------------------------------------------------------------------
module qar_dmem_responder #(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_valid,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        mem_err,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count,
   output logic [7:0]  err_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

   state_t      state_q;
   logic [3:0]  wait_cnt_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        ready_q;
   logic        err_q;
   logic [31:0] rdata_q;
   logic [15:0] rd_count_q;
   logic [15:0] wr_count_q;
   logic [7:0]  err_count_q;

   // Storage is deliberately not reset.
   logic [31:0] mem_q [DEPTH];

   // While idle the live bus inputs describe the request being accepted; in
   // every other state the latched copy is used. This lets a zero-wait-state
   // access compute its response on the very edge that accepts it.
   logic                  req_we;
   logic [31:0]           req_addr;
   logic [31:0]           req_offset;
   logic                  req_fault;
   logic [ADDR_WIDTH-1:0] req_widx;
   logic                  enter_resp;

   assign req_addr   = (state_q == S_IDLE) ? mem_addr : addr_q;
   assign req_we     = (state_q == S_IDLE) ? mem_we   : we_q;
   assign req_offset = req_addr - BASE_ADDR;
   assign req_fault  = (req_addr[1:0] != 2'b00)
                    || (req_addr < BASE_ADDR)
                    || ((req_offset >> 2) >= DEPTH);
   assign req_widx   = req_offset[ADDR_WIDTH+1:2];

   // True on the edge that moves the FSM into RESP.
   assign enter_resp = ((state_q == S_IDLE) && mem_valid && (WAIT_STATES == 0))
                    || ((state_q == S_WAIT) && (wait_cnt_q == 4'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wait_cnt_q  <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         rd_count_q  <= '0;
         wr_count_q  <= '0;
         err_count_q <= '0;
      end else begin
         ready_q <= enter_resp;
         err_q   <= enter_resp && req_fault;
         if (enter_resp && !req_we) begin
            rdata_q <= req_fault ? 32'hDEAD_BEEF : mem_q[req_widx];
         end

         case (state_q)
            S_IDLE: begin
               if (mem_valid) begin
                  we_q       <= mem_we;
                  addr_q     <= mem_addr;
                  wdata_q    <= mem_wdata;
                  wait_cnt_q <= WAIT_LOAD;
                  state_q    <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               wait_cnt_q <= wait_cnt_q - 4'd1;
               if (wait_cnt_q == 4'd1) begin
                  state_q <= S_RESP;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
               if (err_q) begin
                  if (err_count_q != 8'hFF) begin
                     err_count_q <= err_count_q + 8'd1;
                  end
               end else if (we_q) begin
                  wr_count_q <= wr_count_q + 16'd1;
               end else begin
                  rd_count_q <= rd_count_q + 16'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // The write commits on the edge that ends RESP. An asynchronous reset
   // forces the FSM out of RESP at once, so a pending write is dropped.
   always_ff @(posedge clk) begin
      if ((state_q == S_RESP) && we_q && !err_q) begin
         mem_q[req_widx] <= wdata_q;
      end
   end

   assign mem_ready = ready_q;
   assign mem_err   = err_q;
   assign mem_rdata = rdata_q;
   assign rd_count  = rd_count_q;
   assign wr_count  = wr_count_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_qar_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_qar_dmem_responder
//   Directed bench for qar_dmem_responder. Three instances run side by side:
//     0: WAIT_STATES=1, BASE_ADDR=0
//     1: WAIT_STATES=0, BASE_ADDR=0x100
//     2: WAIT_STATES=3, BASE_ADDR=0
//   Each instance has its own reset and request signals.
// -----------------------------------------------------------------------------
module tb_qar_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]        rst_n;
   logic [2:0]        valid;
   logic [2:0]        we;
   logic [2:0][31:0]  addr;
   logic [2:0][31:0]  wdata;
   logic [2:0]        ready;
   logic [2:0]        err;
   logic [2:0][31:0]  rdata;
   logic [2:0][15:0]  rdc;
   logic [2:0][15:0]  wrc;
   logic [2:0][7:0]   errc;

   int checks = 0;
   int errors = 0;

   qar_dmem_responder #(.WAIT_STATES(1)) u_ws1 (
      .clk(clk), .rst_n(rst_n[0]), .mem_valid(valid[0]), .mem_we(we[0]),
      .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_ready(ready[0]),
      .mem_rdata(rdata[0]), .mem_err(err[0]), .rd_count(rdc[0]),
      .wr_count(wrc[0]), .err_count(errc[0])
   );

   qar_dmem_responder #(.WAIT_STATES(0), .BASE_ADDR(32'h0000_0100)) u_ws0 (
      .clk(clk), .rst_n(rst_n[1]), .mem_valid(valid[1]), .mem_we(we[1]),
      .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_ready(ready[1]),
      .mem_rdata(rdata[1]), .mem_err(err[1]), .rd_count(rdc[1]),
      .wr_count(wrc[1]), .err_count(errc[1])
   );

   qar_dmem_responder #(.WAIT_STATES(3)) u_ws3 (
      .clk(clk), .rst_n(rst_n[2]), .mem_valid(valid[2]), .mem_we(we[2]),
      .mem_addr(addr[2]), .mem_wdata(wdata[2]), .mem_ready(ready[2]),
      .mem_rdata(rdata[2]), .mem_err(err[2]), .rd_count(rdc[2]),
      .wr_count(wrc[2]), .err_count(errc[2])
   );

   // Issue one access on instance d and wait (bounded) for mem_ready.
   // lat = number of rising edges from the request being raised until
   // mem_ready is seen; 0 means it never arrived. With hold=1 mem_valid stays
   // high so the caller can chain the next request without a bubble.
   task automatic access(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input bit hold,
                         output logic [31:0] rd, output logic er, output int lat);
      valid[d] = 1'b1;
      we[d]    = w;
      addr[d]  = a;
      wdata[d] = wd;
      lat = 0;
      rd  = '0;
      er  = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (ready[d] === 1'b1) begin
            lat = k;
            rd  = rdata[d];
            er  = err[d];
            break;
         end
      end
      if (!hold) valid[d] = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({ready[d], err[d], rdata[d], rdc[d], wrc[d], errc[d]} !== '0) begin
            errors++;
            $display("FAIL reset_state[%0d]: got rdy=%b err=%b rdata=%h rd=%0d wr=%0d ec=%0d expected all zero",
                     d, ready[d], err[d], rdata[d], rdc[d], wrc[d], errc[d]);
         end
      end
      rst_n = '1;
   endtask

   task automatic test_write_read();
      logic [31:0] rd;
      logic        er;
      int          lat;
      // Issued in the same cycle reset is released: first edge must accept.
      access(0, 1'b1, 32'h48, 32'h1234_5678, 1'b0, rd, er, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", lat); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", er); end
      @(posedge clk); #1;
      access(0, 1'b0, 32'h48, 32'h0, 1'b0, rd, er, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", lat); end
      checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h expected 12345678", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", er); end
      @(posedge clk); #1;
      checks++; if (wrc[0] !== 16'd1) begin errors++; $display("FAIL wr_count_1: got %0d expected 1", wrc[0]); end
      checks++; if (rdc[0] !== 16'd1) begin errors++; $display("FAIL rd_count_1: got %0d expected 1", rdc[0]); end
      // Write then immediately read the same word with no bubble.
      access(0, 1'b1, 32'h4C, 32'hA5A5_0F0F, 1'b1, rd, er, lat);
      checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL rdata_hold_on_write: got %h expected 12345678", rd); end
      access(0, 1'b0, 32'h4C, 32'h0, 1'b0, rd, er, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL raw_latency: got %0d expected 3", lat); end
      checks++; if (rd !== 32'hA5A5_0F0F) begin errors++; $display("FAIL raw_data: got %h expected a5a50f0f", rd); end
   endtask

   task automatic test_fault();
      logic [31:0] rd;
      logic        er;
      int          lat;
      @(posedge clk); #1;
      access(0, 1'b0, 32'h401, 32'h0, 1'b0, rd, er, lat);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b expected 1", er); end
      checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL misalign_rdata: got %h expected deadbeef", rd); end
      access(0, 1'b0, 32'h400, 32'h0, 1'b0, rd, er, lat);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL range_err: got %b expected 1", er); end
      checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL range_rdata: got %h expected deadbeef", rd); end
      // Misaligned write aimed at word 0x48 must not land.
      access(0, 1'b1, 32'h49, 32'hFFFF_FFFF, 1'b0, rd, er, lat);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL fault_wr_err: got %b expected 1", er); end
      @(posedge clk); #1;
      checks++; if (errc[0] !== 8'd3) begin errors++; $display("FAIL err_count_3: got %0d expected 3", errc[0]); end
      checks++; if (wrc[0] !== 16'd2) begin errors++; $display("FAIL fault_wr_count: got %0d expected 2", wrc[0]); end
      checks++; if (rdc[0] !== 16'd2) begin errors++; $display("FAIL fault_rd_count: got %0d expected 2", rdc[0]); end
      access(0, 1'b0, 32'h48, 32'h0, 1'b0, rd, er, lat);
      checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL array_unchanged: got %h expected 12345678", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL good_after_fault_err: got %b expected 0", er); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic [31:0] exp;
      logic        er;
      int          lat;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         exp = 32'hC0DE_0000 + 32'(i) * 32'h11;
         access(1, 1'b1, 32'h100 + 32'(i) * 4, exp, (i != 7), rd, er, lat);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         exp = 32'hC0DE_0000 + 32'(i) * 32'h11;
         access(1, 1'b0, 32'h100 + 32'(i) * 4, 32'h0, (i != 7), rd, er, lat);
         checks++; if (rd !== exp) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, rd, exp); end
         checks++; if (lat !== ((i == 0) ? 1 : 2)) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, lat, (i == 0) ? 1 : 2); end
         checks++; if (er !== 1'b0) begin errors++; $display("FAIL b2b_err[%0d]: got %b expected 0", i, er); end
      end
      @(posedge clk); #1;
      checks++; if (rdc[1] !== 16'd8) begin errors++; $display("FAIL b2b_rd_count: got %0d expected 8", rdc[1]); end
      checks++; if (wrc[1] !== 16'd8) begin errors++; $display("FAIL b2b_wr_count: got %0d expected 8", wrc[1]); end
   endtask

   task automatic test_saturation();
      logic [31:0] rd;
      logic [31:0] a;
      logic        er;
      int          lat;
      int          nflag;
      @(posedge clk); #1;
      for (int i = 0; i < 300; i++) begin
         access(1, 1'b1, 32'h100 + 32'(i % 256) * 4, 32'(i), (i != 299), rd, er, lat);
      end
      @(posedge clk); #1;
      checks++; if (errc[1] !== 8'd0) begin errors++; $display("FAIL good_writes_err_count: got %0d expected 0", errc[1]); end
      checks++; if (wrc[1] !== 16'd308) begin errors++; $display("FAIL good_writes_wr_count: got %0d expected 308", wrc[1]); end
      nflag = 0;
      for (int i = 0; i < 256; i++) begin
         if (i == 0)          a = 32'h0000_00FC;
         else if (i % 2 == 1) a = 32'h101 + 32'(i) * 4;
         else                 a = 32'h500 + 32'(i) * 4;
         access(1, 1'b0, a, 32'h0, (i != 255), rd, er, lat);
         if (er === 1'b1 && rd === 32'hDEAD_BEEF) nflag++;
      end
      checks++; if (nflag !== 256) begin errors++; $display("FAIL faults_flagged: got %0d expected 256", nflag); end
      @(posedge clk); #1;
      checks++; if (errc[1] !== 8'hFF) begin errors++; $display("FAIL err_count_saturate: got %h expected ff", errc[1]); end
      checks++; if (rdc[1] !== 16'd8) begin errors++; $display("FAIL sat_rd_count: got %0d expected 8", rdc[1]); end
      checks++; if (wrc[1] !== 16'd308) begin errors++; $display("FAIL sat_wr_count: got %0d expected 308", wrc[1]); end
      access(1, 1'b0, 32'h114, 32'h0, 1'b0, rd, er, lat);
      checks++; if (rd !== 32'd261) begin errors++; $display("FAIL overwritten_word: got %0d expected 261", rd); end
   endtask

   task automatic test_wait_drop();
      logic [31:0] rd;
      logic        er;
      int          lat;
      @(posedge clk); #1;
      valid[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h10; wdata[2] = 32'hBEEF_0001;
      @(posedge clk); #1;
      checks++; if (ready[2] !== 1'b0) begin errors++; $display("FAIL ws3_early_ready: got %b expected 0", ready[2]); end
      // Drop the strobe and scramble the bus mid-transaction.
      valid[2] = 1'b0; we[2] = 1'b0; addr[2] = 32'h14; wdata[2] = 32'h0BAD_0BAD;
      lat = 0;
      for (int k = 2; k <= 20; k++) begin
         @(posedge clk); #1;
         if (ready[2] === 1'b1) begin lat = k; break; end
      end
      checks++; if (lat !== 4) begin errors++; $display("FAIL ws3_latency: got %0d expected 4", lat); end
      checks++; if (err[2] !== 1'b0) begin errors++; $display("FAIL ws3_err: got %b expected 0", err[2]); end
      @(posedge clk); #1;
      checks++; if (wrc[2] !== 16'd1) begin errors++; $display("FAIL ws3_wr_count: got %0d expected 1", wrc[2]); end
      checks++; if (rdc[2] !== 16'd0) begin errors++; $display("FAIL ws3_rd_count: got %0d expected 0", rdc[2]); end
      access(2, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat);
      checks++; if (rd !== 32'hBEEF_0001) begin errors++; $display("FAIL ws3_latched_data: got %h expected beef0001", rd); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL ws3_rd_latency: got %0d expected 4", lat); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic        er;
      int          lat;
      bit          seen;
      @(posedge clk); #1;
      access(2, 1'b1, 32'h50, 32'h1111_2222, 1'b0, rd, er, lat);
      @(posedge clk); #1;
      valid[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h50; wdata[2] = 32'h3333_4444;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n[2] = 1'b0;
      #1;
      checks++; if (rdata[2] !== 32'h0) begin errors++; $display("FAIL async_rdata: got %h expected 0", rdata[2]); end
      checks++; if (wrc[2] !== 16'd0) begin errors++; $display("FAIL async_wr_count: got %0d expected 0", wrc[2]); end
      checks++; if (rdc[2] !== 16'd0) begin errors++; $display("FAIL async_rd_count: got %0d expected 0", rdc[2]); end
      checks++; if ({ready[2], err[2], errc[2]} !== '0) begin errors++; $display("FAIL async_ctrl: got rdy=%b err=%b ec=%0d expected 0", ready[2], err[2], errc[2]); end
      valid[2] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n[2] = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (ready[2] !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL no_ready_after_reset: got %b expected 0", seen); end
      access(2, 1'b0, 32'h50, 32'h0, 1'b0, rd, er, lat);
      checks++; if (rd !== 32'h1111_2222) begin errors++; $display("FAIL discarded_write: got %h expected 11112222", rd); end
   endtask

   initial begin
      rst_n = '0;
      valid = '0;
      we    = '0;
      addr  = '0;
      wdata = '0;
      test_reset();
      test_write_read();
      test_fault();
      test_back_to_back();
      test_saturation();
      test_wait_drop();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/qar_dmem_responder.md
QAR_DMEM_RESPONDER -- requirements
Module: qar_dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words in the storage array.
REQ-002 Parameter ADDR_WIDTH, default 8, word-index width (log2 DEPTH).
REQ-003 Parameter WAIT_STATES, default 1, range 0..15, extra cycles between acceptance and mem_ready.
REQ-004 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-005 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 Port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-007 Port mem_valid, input, 1, initiator request strobe, held until mem_ready seen.
REQ-008 Port mem_we, input, 1, 1 = write, 0 = read.
REQ-009 Port mem_addr, input, 32, byte address.
REQ-010 Port mem_wdata, input, 32, write data.
REQ-011 Port mem_ready, output, 1, one-cycle completion pulse.
REQ-012 Port mem_rdata, output, 32, read data, valid while mem_ready=1 for a read.
REQ-013 Port mem_err, output, 1, error flag, pulses with mem_ready for a faulting access.
REQ-014 Port rd_count, output, 16, completed good reads, wraps at 16'hFFFF.
REQ-015 Port wr_count, output, 16, completed good writes, wraps at 16'hFFFF.
REQ-016 Port err_count, output, 8, faulting accesses, saturates at 8'hFF.

Function
REQ-017 FSM states IDLE, WAIT, RESP; encoding free.
REQ-018 IDLE: mem_valid=1 at a rising edge -> accept; latch mem_we, mem_addr, mem_wdata; go WAIT if WAIT_STATES>0, else RESP.
REQ-019 WAIT: internal counter loaded with WAIT_STATES at acceptance, decremented each cycle; go RESP on the cycle it reaches 1.
REQ-020 RESP: mem_ready=1 for exactly one cycle; next state IDLE unconditionally.
REQ-021 Latency: request accepted at edge T -> mem_ready high in cycle T+1+WAIT_STATES.
REQ-022 Back-to-back: mem_valid high in the IDLE cycle after RESP is a new request; accept it; no extra bubble.
REQ-023 Inputs changing while in WAIT/RESP are ignored; latched values are used.
REQ-024 mem_valid dropped mid-transaction: no abort; transaction completes and mem_ready still pulses.
REQ-025 Word index = (latched addr - BASE_ADDR) >> 2, width 32 before range check.
REQ-026 Fault: latched addr[1:0] != 2'b00, addr < BASE_ADDR, or index >= DEPTH.
REQ-027 Good write: array[index] <= wdata on the edge ending the RESP cycle; wr_count +1.
REQ-028 Good read: mem_rdata = array[index] in RESP cycle; rd_count +1.
REQ-029 Faulting access: no array write; mem_rdata = 32'hDEAD_BEEF for reads; mem_err=1 with mem_ready; err_count +1 saturating; rd/wr counts unchanged.
REQ-030 mem_rdata holds its last driven value outside RESP; writes do not change it.
REQ-031 mem_err is 0 whenever mem_ready is 0.
REQ-032 Read-after-write to same word in consecutive transactions returns the new data.

Reset
REQ-033 rst_n=0 -> FSM IDLE, wait counter 0, mem_ready 0, mem_err 0, mem_rdata 0, rd_count 0, wr_count 0, err_count 0, immediately (asynchronous).
REQ-034 Array contents are not reset; simulation may preload via $readmemh.
REQ-035 Reset during WAIT/RESP: pending write is discarded; no mem_ready pulse issued.
REQ-036 First request is accepted at the first rising edge with rst_n=1 and mem_valid=1.

Verification
REQ-037 WAIT_STATES=1: write 32'h1234_5678 to 0x48, then read 0x48 -> each mem_ready 2 cycles after acceptance, rdata 32'h1234_5678, wr_count=1, rd_count=1.
REQ-038 WAIT_STATES=0, 8 back-to-back reads of preloaded words 0..7 -> mem_ready every other cycle, data matches preload, rd_count=8.
REQ-039 Read 0x401 (misaligned) and 0x400 (index 256) -> mem_err with mem_ready both times, rdata 32'hDEAD_BEEF, err_count=2, array unchanged.
REQ-040 WAIT_STATES=3, write accepted then mem_valid dropped after 1 cycle -> mem_ready still at T+4, word written.
REQ-041 Assert rst_n=0 during WAIT of a write to 0x50 -> no mem_ready, word 20 keeps old value, all counters 0.
REQ-042 300 good writes -> err_count 0; 256 faulting accesses -> err_count holds 8'hFF.
